yolo_conv_acc_requant: RTL and testbench

- Downstream neighbour of the conv-top 6-bit-unsigned × 16-bit-signed multiplier, which produces 22-bit signed products.
- Accumulates a stream of those products over one kernel window (K×K×Cin taps), adds the channel bias, then rounds, right-shifts and saturates to the 16-bit feature-map format.
- Emits one output pixel per window over a valid/ready stream into the output line buffer.

---
 rtl/yolo_conv_pkg.sv | 24 ++
 rtl/yolo_conv_requant.sv | 50 +++++
 rtl/yolo_conv_acc_requant.sv | 127 ++++++++++++
 tb/tb_yolo_conv_acc_requant.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/yolo_conv_pkg.sv
// Shared widths, FSM encoding and requant constants for the conv accumulate/requant stage.
// Optional leaky-ReLU constants are consumed only when YOLO_CONV_LEAKY_RELU_EN is defined.
package yolo_conv_pkg;

    localparam int PROD_W = 22;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 10;
    localparam int ACC_W  = PROD_W + LEN_W;
    localparam int SH_W   = 4;
    // Two guard bits cover acc + shifted bias + rounding constant without wrap.
    localparam int SUM_W  = ACC_W + 2;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_e;

    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    localparam int LEAKY_MUL = 13;
    localparam int LEAKY_SH  = 7;

endpackage

// File: rtl/yolo_conv_requant.sv
// Combinational bias-add, round-half-up, arithmetic shift and saturate to the feature-map format.
// Macro YOLO_CONV_LEAKY_RELU_EN adds a floor((r*13)/128) slope for negative results.
module yolo_conv_requant
    import yolo_conv_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [DATA_W-1:0] bias_i,
    input  logic        [SH_W-1:0]   shift_i,
    output logic signed [DATA_W-1:0] data_o
);

    localparam logic signed [SUM_W-1:0] SAT_HI = {{(SUM_W-DATA_W){DATA_MAX[DATA_W-1]}}, DATA_MAX};
    localparam logic signed [SUM_W-1:0] SAT_LO = {{(SUM_W-DATA_W){DATA_MIN[DATA_W-1]}}, DATA_MIN};

    logic signed [SUM_W-1:0]  bias_x;
    logic signed [SUM_W-1:0]  rnd;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [DATA_W-1:0] sat;

    always_comb begin
        bias_x  = {{(SUM_W-DATA_W){bias_i[DATA_W-1]}}, bias_i} <<< shift_i;
        rnd     = (shift_i == '0) ? '0 : (SUM_W'(1) << (shift_i - SH_W'(1)));
        sum     = {{(SUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i} + bias_x + rnd;
        shifted = sum >>> shift_i;
        if (shifted > SAT_HI) begin
            sat = DATA_MAX;
        end else if (shifted < SAT_LO) begin
            sat = DATA_MIN;
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

`ifdef YOLO_CONV_LEAKY_RELU_EN
    localparam int LK_W = DATA_W + 4;

    logic signed [LK_W-1:0] lk_mul;
    logic signed [LK_W-1:0] lk_sh;

    always_comb begin
        lk_mul = {{(LK_W-DATA_W){sat[DATA_W-1]}}, sat} * $signed(LK_W'(LEAKY_MUL));
        lk_sh  = lk_mul >>> LEAKY_SH;
        data_o = sat[DATA_W-1] ? lk_sh[DATA_W-1:0] : sat;
    end
`else
    assign data_o = sat;
`endif

endmodule

// File: rtl/yolo_conv_acc_requant.sv
// Accumulates one kernel window of products, then emits one requantised pixel per window.
// Pixel valid one cycle after the final beat; prod_tready drops while the pixel waits for out_tready.
module yolo_conv_acc_requant
    import yolo_conv_pkg::*;
(
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic        [LEN_W-1:0]  cfg_len,
    input  logic signed [DATA_W-1:0] cfg_bias,
    input  logic        [4:0]        cfg_shift,
    input  logic signed [PROD_W-1:0] prod_tdata,
    input  logic                     prod_tvalid,
    output logic                     prod_tready,
    input  logic                     prod_tlast,
    output logic signed [DATA_W-1:0] out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     err_last
);

    state_e                   state_q, state_d;
    logic        [LEN_W-1:0]  cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [LEN_W-1:0]  len_q, len_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic        [SH_W-1:0]   shift_q, shift_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     err_q, err_d;
    // Holds prod_tready low for the first cycle after reset release.
    logic                     live_q;

    logic                     beat;
    logic                     first;
    logic                     at_end;
    logic                     close;
    logic        [LEN_W-1:0]  len_in;
    logic        [SH_W-1:0]   shift_in;
    logic        [LEN_W-1:0]  cur_len;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [DATA_W-1:0] rq_data;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            len_q   <= '0;
            bias_q  <= '0;
            shift_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            bias_q  <= bias_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close)      state_d = OUTPUT;
            OUTPUT:  if (out_tready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        prod_tready = (state_q == ACCUM) && live_q;
        out_tvalid  = (state_q == OUTPUT);
        out_tdata   = out_q;
        err_last    = err_q;
    end

    // On the opening beat the shadow registers are not yet loaded, so the live cfg is used.
    always_comb begin
        beat     = prod_tvalid && prod_tready;
        first    = (cnt_q == '0);
        len_in   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        shift_in = (cfg_shift > 5'd15) ? SH_W'(15) : cfg_shift[SH_W-1:0];
        cur_len  = first ? len_in : len_q;
        at_end   = (cnt_q == cur_len - LEN_W'(1));
        close    = beat && at_end;
        prod_x   = {{(ACC_W-PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};

        len_d   = len_q;
        bias_d  = bias_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        out_d   = out_q;

        if (beat) begin
            if (first) begin
                len_d   = len_in;
                bias_d  = cfg_bias;
                shift_d = shift_in;
                acc_d   = prod_x;
            end else begin
                acc_d   = acc_q + prod_x;
            end
            cnt_d = at_end ? '0 : cnt_q + LEN_W'(1);
            if (prod_tlast != at_end) begin
                err_d = 1'b1;
            end
        end
        if (close) begin
            out_d = rq_data;
        end
    end

    yolo_conv_requant u_requant (
        .acc_i   (acc_d),
        .bias_i  (bias_d),
        .shift_i (shift_d),
        .data_o  (rq_data)
    );

endmodule

// File: tb/tb_yolo_conv_acc_requant.sv
// Scoreboard bench: expected pixels queued when a window is driven, popped on each output handshake.
module tb_yolo_conv_acc_requant;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic        [9:0]  cfg_len;
    logic signed [15:0] cfg_bias;
    logic        [4:0]  cfg_shift;
    logic signed [21:0] prod_tdata;
    logic               prod_tvalid;
    logic               prod_tready;
    logic               prod_tlast;
    logic signed [15:0] out_tdata;
    logic               out_tvalid;
    logic               out_tready;
    logic               err_last;

    int     n_cmp = 0;
    int     n_err = 0;
    longint exp_q[$];
    longint pv[16];

    always #5 ap_clk = ~ap_clk;

    yolo_conv_acc_requant dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .cfg_len     (cfg_len),
        .cfg_bias    (cfg_bias),
        .cfg_shift   (cfg_shift),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .prod_tlast  (prod_tlast),
        .out_tdata   (out_tdata),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .err_last    (err_last)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, floor division written without shifts.
    function automatic longint model(input longint acc, input longint bias, input int sh);
        int     s;
        longint p, v;
        s = (sh > 15) ? 15 : sh;
        p = 64'sd1 << s;
        v = acc + bias * p + ((s == 0) ? 0 : p / 2);
        v = (v >= 0) ? (v / p) : -((-v + p - 1) / p);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`ifdef YOLO_CONV_LEAKY_RELU_EN
        if (v < 0) v = -((-v * 13 + 127) / 128);
`endif
        return v;
    endfunction

    always @(negedge ap_clk) begin
        if (ap_rst_n && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) chk("spurious_pix", 1, 0);
            else                   chk("pix", longint'(out_tdata), exp_q.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input longint d, input bit l);
        int g = 0;
        prod_tdata  = d[21:0];
        prod_tlast  = l;
        prod_tvalid = 1'b1;
        @(negedge ap_clk);
        while (!prod_tready && g < 100) begin
            @(negedge ap_clk);
            g++;
        end
        if (g >= 100) chk("rdy_timeout", 0, 1);
        @(posedge ap_clk); #1;
        prod_tvalid = 1'b0;
        prod_tlast  = 1'b0;
    endtask

    task automatic run_window(input int len, input int bias, input int sh, input int n, input int tl);
        longint sum = 0;
        cfg_len   = len[9:0];
        cfg_bias  = bias[15:0];
        cfg_shift = sh[4:0];
        for (int i = 0; i < n; i++) sum += pv[i];
        exp_q.push_back(model(sum, bias, sh));
        for (int i = 0; i < n; i++) send_beat(pv[i], i == tl);
        @(negedge ap_clk);
        chk("latency_vld", out_tvalid, 1);
        @(posedge ap_clk); #1;
    endtask

    initial begin
        ap_rst_n = 1'b0; out_tready = 1'b1;
        cfg_len = '0; cfg_bias = '0; cfg_shift = '0;
        prod_tdata = '0; prod_tvalid = 1'b0; prod_tlast = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_vld", out_tvalid, 0);
        chk("rst_dat", out_tdata, 0);
        chk("rst_err", err_last, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_rdy_first", prod_tready, 0);
        @(posedge ap_clk); #1;

        pv[0] = 100; pv[1] = 200; pv[2] = 300;
        run_window(3, 0, 0, 3, 2);                 // 600
        chk("err_clean", err_last, 0);
        pv[0] = 5;  run_window(1, 0, 1, 1, 0);     // 3
        pv[0] = -5; run_window(1, 0, 1, 1, 0);     // -2
        pv[0] = 7;  run_window(0, 0, 0, 1, 0);     // len 0 acts as 1
        pv[0] = 2097151;  pv[1] = 2097151;  run_window(2, 0, 0, 2, 1);
        pv[0] = -2097152; pv[1] = -2097152; run_window(2, 0, 0, 2, 1);
        pv[0] = 0;  run_window(1, 1, 20, 1, 0);    // shift clamps to 15
        pv[0] = 3;  run_window(1, 5, 2, 1, 0);     // 6
        pv[0] = -100; run_window(1, 0, 0, 1, 0);   // leaky -11 / linear -100

        // Mid-window cfg change must not touch the open window.
        cfg_len = 3; cfg_bias = 0; cfg_shift = 0;
        exp_q.push_back(model(7, 0, 0));
        send_beat(1, 0);
        cfg_len = 1; cfg_shift = 3; cfg_bias = 100;
        send_beat(2, 0);
        @(negedge ap_clk);
        chk("cfgchg_open", out_tvalid, 0);
        @(posedge ap_clk); #1;
        send_beat(4, 1);
        @(negedge ap_clk);
        chk("cfgchg_close", out_tvalid, 1);
        @(posedge ap_clk); #1;

        // Output stall with the next window's first product already pending.
        out_tready = 1'b0;
        pv[0] = 10; pv[1] = 20; run_window(2, 0, 0, 2, 1);
        prod_tdata = 7; prod_tvalid = 1'b1;
        repeat (5) begin
            @(negedge ap_clk);
            chk("stall_vld", out_tvalid, 1);
            chk("stall_dat", out_tdata, 30);
            chk("stall_rdy", prod_tready, 0);
        end
        @(posedge ap_clk); #1;
        out_tready = 1'b1;
        pv[0] = 7; pv[1] = 8; run_window(2, 0, 0, 2, 1);

        // Early tlast: flag sticks, window still closes on the count.
        cfg_len = 4; cfg_bias = 0; cfg_shift = 0;
        exp_q.push_back(model(4, 0, 0));
        send_beat(1, 0); send_beat(1, 0); send_beat(1, 1);
        @(negedge ap_clk);
        chk("err_set", err_last, 1);
        chk("early_last_open", out_tvalid, 0);
        @(posedge ap_clk); #1;
        send_beat(1, 0);
        @(negedge ap_clk);
        chk("count_close", out_tvalid, 1);
        @(posedge ap_clk); #1;
        pv[0] = 9; run_window(1, 0, 0, 1, 0);
        chk("err_sticky", err_last, 1);

        // Reset mid-window discards the partial sum.
        cfg_len = 3;
        send_beat(50, 0); send_beat(60, 0);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_vld", out_tvalid, 0);
        chk("midrst_err", err_last, 0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("midrst_rdy_first", prod_tready, 0);
        @(posedge ap_clk); #1;
        pv[0] = 1; pv[1] = 2; pv[2] = 3; run_window(3, 0, 0, 3, 2);

        repeat (3) @(posedge ap_clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
